alpha_row_shifter: RTL and testbench

//  Reader side of the alpha character ROM: takes a stream of 8-bit character codes for one

---
 rtl/alpha_row_shifter.sv | 139 +++++++++++++
 tb/tb_alpha_row_shifter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alpha_row_shifter.sv
// rtl/alpha_row_shifter.sv - alpha character ROM reader: glyph row lookup and MSB-first pixel serialiser
module alpha_row_shifter #(
    parameter int CHARS_PER_LINE = 32,
    parameter int CELL_LINES     = 12,
    parameter int GLYPH_TOP      = 3,
    parameter int GLYPH_ROWS     = 7
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PixelEn,
    input  logic       LineStart,
    input  logic [3:0] LineNum,
    output logic       CharReq,
    input  logic       CharValid,
    input  logic [7:0] CharCode,
    output logic [5:0] RomData,
    output logic [3:0] RomRow,
    input  logic [7:0] RomAData,
    output logic       Pixel,
    output logic       PixelValid,
    output logic       LineDone,
    output logic       Underrun
);

    localparam int CW = $clog2(CHARS_PER_LINE + 1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t          state, state_next;
    logic [7:0]      shift_reg;
    logic [7:0]      pending;
    logic            pending_full;
    logic [2:0]      bit_cnt;
    logic [CW-1:0]   char_cnt;
    logic            in_glyph;
    logic            line_end;

    logic            line_in_glyph;
    logic [7:0]      glyph;
    logic            full_cnt;
    logic            accept;
    logic            boundary;
    logic            unused_code_bit;

    assign unused_code_bit = CharCode[7];

    // Out-of-range cell lines fall outside the glyph window and render blank.
    assign line_in_glyph = (int'(LineNum) >= GLYPH_TOP) &&
                           (int'(LineNum) < GLYPH_TOP + GLYPH_ROWS) &&
                           (int'(LineNum) < CELL_LINES);

    assign RomData  = CharCode[5:0];
    assign glyph    = (in_glyph ? RomAData : 8'h00) ^ {8{CharCode[6]}};
    assign full_cnt = (char_cnt == CW'(CHARS_PER_LINE));
    assign CharReq  = (state == PRIME) || ((state == RUN) && !pending_full && !full_cnt);
    assign accept   = CharReq && CharValid;
    assign boundary = (state == RUN) && PixelEn && (bit_cnt == 3'd7);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (LineStart) state_next = PRIME;
            PRIME:   if (LineStart) state_next = PRIME;
                     else if (accept) state_next = RUN;
            RUN:     if (LineStart) state_next = PRIME;
                     else if (boundary && !pending_full && !accept && full_cnt) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            shift_reg    <= 8'h00;
            pending      <= 8'h00;
            pending_full <= 1'b0;
            bit_cnt      <= 3'd0;
            char_cnt     <= '0;
            in_glyph     <= 1'b0;
            line_end     <= 1'b0;
            RomRow       <= 4'd0;
            Pixel        <= 1'b0;
            PixelValid   <= 1'b0;
            LineDone     <= 1'b0;
            Underrun     <= 1'b0;
        end else begin
            state      <= state_next;
            LineDone   <= line_end;
            line_end   <= 1'b0;
            PixelValid <= 1'b0;
            if (LineStart) begin
                RomRow       <= line_in_glyph ? (LineNum - 4'(GLYPH_TOP)) : 4'd0;
                in_glyph     <= line_in_glyph;
                shift_reg    <= 8'h00;
                pending      <= 8'h00;
                pending_full <= 1'b0;
                bit_cnt      <= 3'd0;
                char_cnt     <= '0;
                Underrun     <= 1'b0;
            end else begin
                if (accept)
                    char_cnt <= char_cnt + CW'(1);
                if (state == PRIME && accept) begin
                    shift_reg <= glyph;
                    bit_cnt   <= 3'd0;
                end
                if (state == RUN) begin
                    if (PixelEn) begin
                        Pixel      <= shift_reg[7];
                        PixelValid <= 1'b1;
                        bit_cnt    <= bit_cnt + 3'd1;
                        shift_reg  <= {shift_reg[6:0], 1'b0};
                    end
                    if (boundary) begin
                        if (pending_full) begin
                            shift_reg <= pending;
                            if (accept)
                                pending <= glyph;
                            else
                                pending_full <= 1'b0;
                        end else if (accept) begin
                            shift_reg <= glyph;
                        end else if (full_cnt) begin
                            line_end <= 1'b1;
                        end else begin
                            // Nothing to show: emit one blank cell and flag the starvation.
                            shift_reg <= 8'h00;
                            Underrun  <= 1'b1;
                        end
                    end else if (accept) begin
                        pending      <= glyph;
                        pending_full <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alpha_row_shifter.sv
// tb/tb_alpha_row_shifter.sv - self-checking bench for alpha_row_shifter
module tb_alpha_row_shifter;

    logic       clk = 1'b0;
    logic       reset, pixel_en, line_start, char_valid;
    logic [3:0] line_num;
    logic [7:0] char_code, rom_a_data;
    logic       char_req, pixel, pixel_valid, line_done, underrun;
    logic [5:0] rom_data;
    logic [3:0] rom_row;

    alpha_row_shifter dut (
        .Clk(clk), .Reset(reset), .PixelEn(pixel_en), .LineStart(line_start),
        .LineNum(line_num), .CharReq(char_req), .CharValid(char_valid),
        .CharCode(char_code), .RomData(rom_data), .RomRow(rom_row),
        .RomAData(rom_a_data), .Pixel(pixel), .PixelValid(pixel_valid),
        .LineDone(line_done), .Underrun(underrun)
    );

    always #5 clk = ~clk;

    // ROM stand-in: 'A' row 0 is 0x08, everything else a deterministic 5-pixel pattern.
    function automatic logic [7:0] rom(input int c, input int r);
        if (c == 1 && r == 0) return 8'h08;
        return 8'(((c * 5 + r * 3 + 7) & 31) << 1);
    endfunction

    always_comb rom_a_data = rom(int'(rom_data), int'(rom_row));

    function automatic logic [7:0] gly(input int ln, input logic [7:0] c);
        logic [7:0] base;
        base = (ln >= 3 && ln < 10) ? rom(int'(c[5:0]), ln - 3) : 8'h00;
        return base ^ {8{c[6]}};
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    logic [7:0] codes [32];
    bit         got_bits[$];
    bit         exp_bits[$];
    int         n_acc, n_done, done_ok, timed_out, row_seen, ur_at_start;

    task automatic run_line(input int ln, input int pe_mode, input int withhold, input int abort_px);
        int idx = 0;
        int last_pv = -10;
        int cyc;
        got_bits.delete();
        n_done = 0; done_ok = 1; timed_out = 1;
        @(negedge clk);
        line_start = 1'b1; line_num = 4'(ln); char_valid = 1'b0; pixel_en = 1'b0;
        @(negedge clk);
        line_start = 1'b0;
        row_seen = int'(rom_row);
        ur_at_start = int'(underrun);
        for (cyc = 0; cyc < 4000; cyc++) begin
            if (pixel_valid) begin got_bits.push_back(pixel); last_pv = cyc; end
            if (line_done) begin n_done++; if (last_pv != cyc - 1) done_ok = 0; end
            if ((n_done > 0 && cyc > last_pv + 3) ||
                (abort_px >= 0 && got_bits.size() == abort_px)) begin
                timed_out = 0;
                break;
            end
            case (pe_mode)
                0:       pixel_en = 1'b1;
                1:       pixel_en = cyc[0];
                default: pixel_en = ($urandom_range(0, 3) != 0);
            endcase
            char_valid = (idx < 32) && !(idx == withhold && !underrun);
            char_code  = (idx < 32) ? codes[idx] : 8'h00;
            if (char_req && char_valid) idx++;
            @(negedge clk);
        end
        n_acc = idx;
        pixel_en = 1'b0; char_valid = 1'b0;
    endtask

    task automatic build_exp(input int ln, input int withhold);
        logic [7:0] g;
        exp_bits.delete();
        for (int i = 0; i < 32; i++) begin
            if (i == withhold) for (int b = 0; b < 8; b++) exp_bits.push_back(1'b0);
            g = gly(ln, codes[i]);
            for (int b = 7; b >= 0; b--) exp_bits.push_back(g[b]);
        end
    endtask

    task automatic check_line(input string name, input int ln, input int withhold, input int exp_ur);
        int mism = 0;
        int n;
        build_exp(ln, withhold);
        n = (got_bits.size() < exp_bits.size()) ? got_bits.size() : exp_bits.size();
        for (int i = 0; i < n; i++) if (got_bits[i] != exp_bits[i]) mism++;
        chk({name, "_timeout"}, timed_out, 0);
        chk({name, "_pixels"}, got_bits.size(), exp_bits.size());
        chk({name, "_bit_mismatches"}, mism, 0);
        chk({name, "_accepts"}, n_acc, 32);
        chk({name, "_linedone_count"}, n_done, 1);
        chk({name, "_linedone_timing"}, done_ok, 1);
        chk({name, "_underrun"}, int'(underrun), exp_ur);
    endtask

    typedef struct {
        int         ln;
        logic [7:0] code;
        logic [7:0] exp_px;
        int         exp_row;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [7:0] first;
        int         pv_cnt, ld_cnt;

        vecs[0] = '{3,  8'h01, 8'h08, 0};
        vecs[1] = '{3,  8'h41, 8'hF7, 0};
        vecs[2] = '{0,  8'h01, 8'h00, 0};
        vecs[3] = '{0,  8'h41, 8'hFF, 0};
        vecs[4] = '{11, 8'h01, 8'h00, 0};
        vecs[5] = '{11, 8'h41, 8'hFF, 0};
        vecs[6] = '{5,  8'h81, 8'h24, 2};
        vecs[7] = '{9,  8'h02, 8'h06, 6};
        vecs[8] = '{10, 8'h01, 8'h00, 0};
        vecs[9] = '{15, 8'h41, 8'hFF, 0};

        reset = 1'b1; pixel_en = 1'b0; line_start = 1'b0; char_valid = 1'b0;
        line_num = 4'd0; char_code = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_charreq", int'(char_req), 0);
        chk("rst_pixel", int'(pixel), 0);
        chk("rst_pixelvalid", int'(pixel_valid), 0);
        chk("rst_linedone", int'(line_done), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_romrow", int'(rom_row), 0);
        reset = 1'b0;

        foreach (vecs[v]) begin
            for (int i = 0; i < 32; i++) codes[i] = vecs[v].code;
            run_line(vecs[v].ln, 0, -1, -1);
            first = 8'h00;
            for (int b = 0; b < 8 && b < got_bits.size(); b++) first[7 - b] = got_bits[b];
            chk($sformatf("vec%0d_first_byte", v), int'(first), int'(vecs[v].exp_px));
            chk($sformatf("vec%0d_romrow", v), row_seen, vecs[v].exp_row);
            chk($sformatf("vec%0d_pixels", v), got_bits.size(), 256);
        end

        for (int i = 0; i < 32; i++) codes[i] = 8'($urandom);
        run_line(4, 1, -1, -1);
        check_line("half_rate", 4, -1, 0);

        for (int r = 0; r < 4; r++) begin
            int ln = $urandom_range(0, 15);
            for (int i = 0; i < 32; i++) codes[i] = 8'($urandom);
            run_line(ln, 2, -1, -1);
            check_line($sformatf("rand%0d", r), ln, -1, 0);
        end

        for (int i = 0; i < 32; i++) codes[i] = 8'($urandom) | 8'h40;
        run_line(6, 0, 1, -1);
        check_line("withhold", 6, 1, 1);
        run_line(6, 0, -1, -1);
        chk("underrun_cleared_by_linestart", ur_at_start, 0);
        check_line("after_underrun", 6, -1, 0);

        for (int i = 0; i < 32; i++) codes[i] = 8'($urandom);
        run_line(5, 0, -1, 100);
        chk("abort_reached_px100", got_bits.size(), 100);
        @(negedge clk); line_start = 1'b1; line_num = 4'd5;
        @(negedge clk); line_start = 1'b0;
        chk("abort_prime_charreq", int'(char_req), 1);
        chk("abort_underrun", int'(underrun), 0);
        pv_cnt = 0; ld_cnt = 0;
        pixel_en = 1'b1;
        repeat (20) begin
            @(negedge clk);
            pv_cnt += int'(pixel_valid);
            ld_cnt += int'(line_done);
        end
        pixel_en = 1'b0;
        chk("abort_no_pixels_in_prime", pv_cnt, 0);
        chk("abort_no_linedone", ld_cnt, 0);
        run_line(5, 0, -1, -1);
        check_line("after_abort", 5, -1, 0);

        for (int i = 0; i < 32; i++) codes[i] = 8'h41;
        run_line(7, 0, -1, 50);
        chk("pre_reset_romrow", int'(rom_row), 4);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("midrst_charreq", int'(char_req), 0);
        chk("midrst_pixel", int'(pixel), 0);
        chk("midrst_pixelvalid", int'(pixel_valid), 0);
        chk("midrst_linedone", int'(line_done), 0);
        chk("midrst_underrun", int'(underrun), 0);
        chk("midrst_romrow", int'(rom_row), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
